// File: rtl/bus_addr_dec_pkg.sv
// Shared types and constants for the bus address decoder.
package bus_addr_dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    // Default four-slave memory map, slave 0 in the LSBs.
    localparam logic [31:0] DEF_BASE = {8'h40, 8'h20, 8'h10, 8'h00};
    localparam logic [31:0] DEF_MASK = {8'hE0, 8'hE0, 8'hF0, 8'hF0};

    // One-hot vector with bit idx set; callers slice to their own width.
    function automatic logic [31:0] onehot(input int unsigned idx);
        onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/bus_addr_dec_if.sv
// Master/slave bus signals seen by the address decoder.
interface bus_addr_dec_if #(
    parameter int AW = 8,
    parameter int NS = 4,
    parameter int CW = 8
);
    logic          M_req;
    logic [AW-1:0] M_addr;
    logic [NS-1:0] S_rdy;
    logic [NS-1:0] S_sel;
    logic          M_busy;
    logic          M_done;
    logic          M_err;
    logic [CW-1:0] err_cnt;

    // Decoder side.
    modport slave (
        input  M_req, M_addr, S_rdy,
        output S_sel, M_busy, M_done, M_err, err_cnt
    );

    // Master / environment side.
    modport master (
        output M_req, M_addr, S_rdy,
        input  S_sel, M_busy, M_done, M_err, err_cnt
    );
endinterface

// File: rtl/bus_addr_dec_match.sv
// Combinational base/mask region match with lowest-index priority.
module bus_addr_match #(
    parameter int               AW   = 8,
    parameter int               NS   = 4,
    parameter logic [NS*AW-1:0] BASE = '0,
    parameter logic [NS*AW-1:0] MASK = '0,
    localparam int              IW   = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic [AW-1:0] addr,
    output logic [NS-1:0] hit,
    output logic [IW-1:0] idx,
    output logic          any_hit
);

    // Per-region compare, then pick the lowest matching index.
    always_comb begin
        hit = '0;
        idx = '0;
        for (int i = 0; i < NS; i++) begin
            hit[i] = ((addr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]));
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if (hit[i]) idx = IW'(i);
        end
        any_hit = |hit;
    end

endmodule

// File: rtl/bus_addr_dec.sv
// Registered address decoder and transaction tracker.
//
//  state     | meaning
//  ST_IDLE   | waiting for M_req; decode sampled on request
//  ST_ACTIVE | slave selected, waiting for its ready or the timeout
//  ST_ERR    | one cycle before the error completion is reported
module bus_addr_dec
    import bus_addr_dec_pkg::*;
#(
    parameter int               AW      = 8,
    parameter int               NS      = 4,
    parameter logic [NS*AW-1:0] BASE    = DEF_BASE,
    parameter logic [NS*AW-1:0] MASK    = DEF_MASK,
    parameter int               TIMEOUT = 15,
    parameter int               CW      = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_addr_dec_if.slave bus
);

    localparam int IW       = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [IW-1:0] idx_q, idx_nxt;
    logic [NS-1:0] sel_nxt;
    logic          busy_nxt, done_nxt, err_nxt;
    logic [CW-1:0] cnt_nxt;

    logic [NS-1:0] hit;
    logic [IW-1:0] match_idx;
    logic          any_hit;
    logic          rdy_sel;
    logic          timeout_hit;

    bus_addr_match #(
        .AW  (AW),
        .NS  (NS),
        .BASE(BASE),
        .MASK(MASK)
    ) u_match (
        .addr   (bus.M_addr),
        .hit    (hit),
        .idx    (match_idx),
        .any_hit(any_hit)
    );

    assign rdy_sel     = bus.S_rdy[idx_q];
    assign timeout_hit = (TIMEOUT != 0) && (timer == TW'(TMO_LAST));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx_q;
        sel_nxt   = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        cnt_nxt   = bus.err_cnt;
        case (state)
            ST_IDLE: begin
                if (bus.M_req) begin
                    if (any_hit) begin
                        state_nxt = ST_ACTIVE;
                        idx_nxt   = match_idx;
                        timer_nxt = '0;
                        // Restricting to hit lanes keeps a bad index from selecting a non-match.
                        sel_nxt   = hit & NS'(onehot(int'(match_idx)));
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_ACTIVE: begin
                // Ready is checked first so it wins over a coincident timeout.
                if (rdy_sel) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (timeout_hit) begin
                    state_nxt = ST_ERR;
                end else begin
                    timer_nxt = timer + TW'(1);
                    sel_nxt   = bus.S_sel;
                end
            end
            ST_ERR: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                err_nxt   = 1'b1;
                if (bus.err_cnt != {CW{1'b1}}) cnt_nxt = bus.err_cnt + CW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State, timer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            idx_q       <= '0;
            bus.S_sel   <= '0;
            bus.M_busy  <= 1'b0;
            bus.M_done  <= 1'b0;
            bus.M_err   <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            idx_q       <= idx_nxt;
            bus.S_sel   <= sel_nxt;
            bus.M_busy  <= busy_nxt;
            bus.M_done  <= done_nxt;
            bus.M_err   <= err_nxt;
            bus.err_cnt <= cnt_nxt;
        end
    end

endmodule
